// File: rtl/riscv_divider.sv
// riscv_divider: 32-bit RISC-V M-extension divider (DIV/DIVU/REM/REMU), radix-2 restoring.
// Divide-by-zero and signed overflow complete in the accepting cycle; all else takes 34 edges.
module riscv_divider (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        flush,
   input  logic [1:0]  DivOp,
   input  logic [31:0] SrcA,
   input  logic [31:0] SrcB,
   output logic [31:0] DivResult,
   output logic        busy,
   output logic        done
);
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, res_q, res_d;
   logic [1:0]  op_q, op_d;
   logic        qneg_q, qneg_d, rneg_q, rneg_d, done_q, done_d;
   logic        sgn, ovf;
   logic [31:0] a_abs, b_abs, q_fix, r_fix;
   logic [32:0] sh, diff;

   assign sgn   = ~DivOp[0];
   assign a_abs = (sgn & SrcA[31]) ? -SrcA : SrcA;
   assign b_abs = (sgn & SrcB[31]) ? -SrcB : SrcB;
   assign ovf   = sgn && SrcA == 32'h8000_0000 && SrcB == 32'hFFFF_FFFF;
   // Partial remainder is always below the divisor, so bit 32 of diff is the borrow.
   assign sh    = {rem_q, quo_q[31]};
   assign diff  = sh - {1'b0, dvs_q};
   assign q_fix = qneg_q ? -quo_q : quo_q;
   assign r_fix = rneg_q ? -rem_q : rem_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      res_d   = res_q;
      op_d    = op_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            op_d = DivOp;
            if (SrcB == 32'd0) begin
               res_d  = DivOp[1] ? SrcA : 32'hFFFF_FFFF;
               done_d = 1'b1;
            end else if (ovf) begin
               res_d  = DivOp[1] ? 32'd0 : 32'h8000_0000;
               done_d = 1'b1;
            end else begin
               rem_d   = 32'd0;
               quo_d   = a_abs;
               dvs_d   = b_abs;
               qneg_d  = sgn & (SrcA[31] ^ SrcB[31]);
               rneg_d  = sgn & SrcA[31];
               cnt_d   = 5'd0;
               state_d = CALC;
            end
         end
         CALC: begin
            rem_d = diff[32] ? sh[31:0] : diff[31:0];
            quo_d = {quo_q[30:0], ~diff[32]};
            cnt_d = cnt_q + 5'd1;
            state_d = (cnt_q == 5'd31) ? FIX : CALC;
         end
         FIX: begin
            res_d   = op_q[1] ? r_fix : q_fix;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d = IDLE;
         done_d  = 1'b0;
         res_d   = res_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         res_q   <= '0;
         op_q    <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         res_q   <= res_d;
         op_q    <= op_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         done_q  <= done_d;
      end
   end

   assign busy      = state_q != IDLE;
   assign done      = done_q;
   assign DivResult = res_q;
endmodule

// File: tb/tb_riscv_divider.sv
// tb_riscv_divider: directed vectors with hand-computed results for riscv_divider.
module tb_riscv_divider;
   logic        clk, rst_n, start, flush;
   logic [1:0]  DivOp;
   logic [31:0] SrcA, SrcB, DivResult;
   logic        busy, done;
   int          total = 0, bad = 0;

   riscv_divider dut (
      .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .DivOp(DivOp),
      .SrcA(SrcA), .SrcB(SrcB), .DivResult(DivResult), .busy(busy), .done(done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge where done is seen.
   task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
      int n;
      DivOp = op; SrcA = a; SrcB = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0; SrcA = ~a; SrcB = ~b; DivOp = ~op;
      n = 1;
      chk({tag, "_busy"}, busy, lat > 1);
      while (!done && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_lat"}, n, lat);
      chk({tag, "_res"}, DivResult, exp);
   endtask

   task automatic count_done(input int cycles, output int cnt);
      cnt = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (done) cnt++;
      end
   endtask

   initial begin
      int dc;
      rst_n = 1'b0; start = 1'b0; flush = 1'b0; DivOp = 2'b00; SrcA = '0; SrcB = '0;
      #1;
      chk("rst_res", DivResult, 32'h0);
      chk("rst_busy", busy, 32'h0);
      chk("rst_done", done, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_op("divu", 2'b01, 32'd100, 32'd7, 32'h0000_000E, 34);
      do_op("remu", 2'b11, 32'd100, 32'd7, 32'h0000_0002, 34);
      do_op("div_neg", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
      do_op("rem_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
      do_op("div_nn", 2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 34);
      do_op("rem_nn", 2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 34);
      do_op("divu_max", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);
      do_op("divu_z", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      do_op("remu_z", 2'b11, 32'd5, 32'd0, 32'h0000_0005, 1);
      do_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      do_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
      @(negedge clk);
      chk("done_one_cycle", done, 32'h0);
      DivOp = 2'b01; SrcA = 32'd100; SrcB = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy", busy, 32'h0);
      chk("flush_done", done, 32'h0);
      chk("flush_res", DivResult, 32'h0);
      count_done(40, dc);
      chk("flush_no_done", dc, 32'd0);
      DivOp = 2'b01; SrcA = 32'd9; SrcB = 32'd3; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      chk("flush_start_busy", busy, 32'h0);
      chk("flush_start_done", done, 32'h0);
      do_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'h0000_0003, 34);
      DivOp = 2'b00; SrcA = 32'd1000; SrcB = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("amid_res", DivResult, 32'h0);
      chk("amid_busy", busy, 32'h0);
      chk("amid_done", done, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      count_done(40, dc);
      chk("rst_no_done", dc, 32'd0);
      DivOp = 2'b01; SrcA = 32'd1000; SrcB = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      DivOp = 2'b01; SrcA = 32'd10; SrcB = 32'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      count_done(60, dc);
      chk("busy_start_dones", dc, 32'd1);
      chk("busy_start_res", DivResult, 32'd333);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
